// File: rtl/dmem_ctl.sv
// dmem_ctl: data-memory controller between the SimpleCore data port and a
// synchronous single-port SRAM. One load or store is in flight at a time.
// Each access holds the SRAM controls for WAIT_CYCLES+1 cycles and then
// acknowledges the core with a one-cycle dAck pulse. All SRAM-side outputs
// are registered.
//
// Optional build macro DMEM_WBUF_EN adds a single-entry posted write buffer.
// Stores are acknowledged the cycle after acceptance and drain in the
// background. A load that hits the buffered address during the drain is
// answered from the buffer without an SRAM access.
module dmem_ctl #(
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 16,
    parameter int DW          = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dReq,
    input  logic          nRW,
    input  logic [AW-1:0] dAddr,
    input  logic [DW-1:0] dWData,
    output logic [DW-1:0] dRData,
    output logic          dAck,
    output logic          dBusy,
    output logic [AW-1:0] mAddr,
    output logic [DW-1:0] mWData,
    input  logic [DW-1:0] mRData,
    output logic          mCe,
    output logic          mWe
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t        state, stateNext;
    logic [3:0]    waitCnt, waitCntNext;
    logic [AW-1:0] mAddrNext;
    logic [DW-1:0] mWDataNext;
    logic [DW-1:0] dRDataNext;
    logic          mCeNext, mWeNext, dAckNext;

`ifdef DMEM_WBUF_EN
    logic          bufValid, bufValidNext;
    logic [AW-1:0] bufAddr, bufAddrNext;
    logic [DW-1:0] bufData, bufDataNext;
    logic          fwdHit;

    // A load may be served from the buffer only while a drain is running and
    // the core is not already being acknowledged for its current request.
    assign fwdHit = (state == ACCESS) && bufValid && dReq && !nRW && !dAck &&
                    (dAddr == bufAddr);
`endif

    assign dBusy = (state != IDLE);

    // Next-state and next-output decode; everything holds unless changed.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        mAddrNext   = mAddr;
        mWDataNext  = mWData;
        mCeNext     = mCe;
        mWeNext     = mWe;
        dRDataNext  = dRData;
        dAckNext    = 1'b0;
`ifdef DMEM_WBUF_EN
        bufValidNext = bufValid;
        bufAddrNext  = bufAddr;
        bufDataNext  = bufData;
`endif
        case (state)
            IDLE: begin
                if (dReq) begin
                    mAddrNext   = dAddr;
                    mWDataNext  = dWData;
                    mWeNext     = nRW;
                    mCeNext     = 1'b1;
                    waitCntNext = WAIT_INIT;
                    stateNext   = ACCESS;
`ifdef DMEM_WBUF_EN
                    // Posted store: capture it and acknowledge right away.
                    if (nRW) begin
                        bufValidNext = 1'b1;
                        bufAddrNext  = dAddr;
                        bufDataNext  = dWData;
                        dAckNext     = 1'b1;
                    end
`endif
                end
            end
            ACCESS: begin
                if (waitCnt != 4'd0) begin
                    waitCntNext = waitCnt - 4'd1;
                end else begin
                    // Read data is valid on the last cycle the SRAM is enabled.
                    if (!mWe) begin
                        dRDataNext = mRData;
                    end
                    mCeNext   = 1'b0;
                    mWeNext   = 1'b0;
                    stateNext = DONE;
`ifdef DMEM_WBUF_EN
                    // A drained store was acknowledged at acceptance.
                    dAckNext     = !mWe;
                    bufValidNext = 1'b0;
`else
                    dAckNext     = 1'b1;
`endif
                end
`ifdef DMEM_WBUF_EN
                if (fwdHit) begin
                    dRDataNext = bufData;
                    dAckNext   = 1'b1;
                end
`endif
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
            mAddr   <= '0;
            mWData  <= '0;
            mCe     <= 1'b0;
            mWe     <= 1'b0;
            dRData  <= '0;
            dAck    <= 1'b0;
`ifdef DMEM_WBUF_EN
            bufValid <= 1'b0;
            bufAddr  <= '0;
            bufData  <= '0;
`endif
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            mAddr   <= mAddrNext;
            mWData  <= mWDataNext;
            mCe     <= mCeNext;
            mWe     <= mWeNext;
            dRData  <= dRDataNext;
            dAck    <= dAckNext;
`ifdef DMEM_WBUF_EN
            bufValid <= bufValidNext;
            bufAddr  <= bufAddrNext;
            bufData  <= bufDataNext;
`endif
        end
    end

endmodule
